// File: rtl/adma_core.sv
// adma_core - Wishbone memory-to-memory DMA copy engine.
//
// The CPU programs a source address, a destination address and a word count
// through the Wishbone slave register file. A START write then launches the
// Wishbone master, which copies 32-bit words one at a time (read, then write).
// On completion or on a bus error it raises wb_int_o if IE is set.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   wbs_*                       slave register port (ack one cycle after stb)
//   wbm_*                       master copy port (single transfers)
//   wb_int_o                    level interrupt, IE & (DONE | ERR)
//   ctrl_state                  FSM state code for debug
//   spi_clk_o/do_o/sel_o/en     bit-bang SPI drive, spi_di_i SPI input
//
// Register map (wbs_adr_i[4:2])
//   0 CTRL   [0] START (write-1 pulse, reads 0), [1] IE
//   1 STATUS [0] BUSY (RO), [1] DONE (W1C), [2] ERR (W1C)
//   2 SRC    3 DST    4 LEN    5 SPI [3:0] clk/do/sel/en, [8] di
//
// Optional feature macro: ADMA_SPI_EN enables the SPI register at offset 5.
// Without it the spi_* outputs are tied 0 and offset 5 reads 0.
//
// state | meaning
// IDLE  | waiting for START
// RD    | reading the source word
// WR    | writing the latched word to the destination
// DONE  | job finished, sets DONE for one cycle
// ERR   | bus error seen, sets ERR for one cycle
module adma_core #(
    parameter int LEN_W = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_cab_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    output logic        wbm_cab_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        wb_int_o,
    output logic [7:0]  ctrl_state,
    output logic        spi_clk_o,
    output logic        spi_do_o,
    output logic        spi_sel_o,
    output logic        spi_en,
    input  logic        spi_di_i
);
    typedef enum logic [7:0] {
        S_IDLE = 8'h00,
        S_RD   = 8'h01,
        S_WR   = 8'h02,
        S_DONE = 8'h03,
        S_ERR  = 8'h04
    } state_t;

    state_t            r_state;
    logic              r_ack;
    logic [31:0]       r_rdat;
    logic              r_ie, r_done, r_err, r_int;
    logic [31:0]       r_src_cfg, r_dst_cfg;
    logic [LEN_W-1:0]  r_len_cfg;
    logic [31:0]       r_src, r_dst;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_cyc, r_stb, r_we, r_gap;
    logic [3:0]        r_sel;
    logic [31:0]       r_adr, r_wdat;

    logic              w_req, w_wr, w_busy, w_start;
    logic [2:0]        w_idx;
    logic [31:0]       w_rd_mux;
    logic              w_unused;

    assign w_req   = wbs_stb_i & wbs_cyc_i;
    assign w_wr    = r_ack & w_req & wbs_we_i;
    assign w_idx   = wbs_adr_i[4:2];
    assign w_busy  = (r_state != S_IDLE);
    assign w_start = w_wr & (w_idx == 3'd0) & wbs_dat_i[0] & ~w_busy;

`ifdef ADMA_SPI_EN
    logic [3:0] r_spi;
    logic       r_spi_di;
    assign spi_clk_o = r_spi[0];
    assign spi_do_o  = r_spi[1];
    assign spi_sel_o = r_spi[2];
    assign spi_en    = r_spi[3];
    assign w_unused  = &{1'b0, wbs_sel_i, wbs_cab_i, wbs_adr_i[31:5], wbs_adr_i[1:0]};
`else
    assign spi_clk_o = 1'b0;
    assign spi_do_o  = 1'b0;
    assign spi_sel_o = 1'b0;
    assign spi_en    = 1'b0;
    assign w_unused  = &{1'b0, wbs_sel_i, wbs_cab_i, wbs_adr_i[31:5], wbs_adr_i[1:0], spi_di_i};
`endif

    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            3'd0: w_rd_mux = {30'b0, r_ie, 1'b0};
            3'd1: w_rd_mux = {29'b0, r_err, r_done, w_busy};
            3'd2: w_rd_mux = r_src_cfg;
            3'd3: w_rd_mux = r_dst_cfg;
            3'd4: w_rd_mux = {{(32-LEN_W){1'b0}}, r_len_cfg};
`ifdef ADMA_SPI_EN
            3'd5: w_rd_mux = {23'b0, r_spi_di, 4'b0, r_spi};
`endif
            default: w_rd_mux = '0;
        endcase
    end

    // Register file: ack one cycle after the request, never two cycles running.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_rdat    <= '0;
            r_ie      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_int     <= 1'b0;
            r_src_cfg <= '0;
            r_dst_cfg <= '0;
            r_len_cfg <= '0;
`ifdef ADMA_SPI_EN
            r_spi     <= '0;
            r_spi_di  <= 1'b0;
`endif
        end else begin
            r_ack  <= w_req & ~r_ack;
            r_rdat <= (w_req & ~r_ack) ? w_rd_mux : '0;
            if (w_wr) begin
                case (w_idx)
                    3'd0: r_ie <= wbs_dat_i[1];
                    3'd1: begin
                        if (wbs_dat_i[1]) r_done <= 1'b0;
                        if (wbs_dat_i[2]) r_err  <= 1'b0;
                    end
                    3'd2: if (!w_busy) r_src_cfg <= wbs_dat_i;
                    3'd3: if (!w_busy) r_dst_cfg <= wbs_dat_i;
                    3'd4: if (!w_busy) r_len_cfg <= wbs_dat_i[LEN_W-1:0];
`ifdef ADMA_SPI_EN
                    3'd5: r_spi <= wbs_dat_i[3:0];
`endif
                    default: ;
                endcase
            end
            if (w_start) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            // Hardware set wins over a simultaneous software clear.
            if (r_state == S_DONE) r_done <= 1'b1;
            if (r_state == S_ERR)  r_err  <= 1'b1;
            r_int <= r_ie & (r_done | r_err);
`ifdef ADMA_SPI_EN
            r_spi_di <= spi_di_i;
`endif
        end
    end

    // Copy FSM. r_gap holds the bus idle for one cycle after every
    // termination (ack or rty) before the next access is issued.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_gap   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_gap <= 1'b0;
                    if (w_start) begin
                        r_src <= r_src_cfg;
                        r_dst <= r_dst_cfg;
                        r_cnt <= r_len_cfg;
                        if (r_len_cfg != '0) begin
                            r_state <= S_RD;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_sel   <= 4'hF;
                            r_we    <= 1'b0;
                            r_adr   <= r_src_cfg;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD, S_WR: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_sel <= 4'hF;
                    end else if (wbm_err_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_sel   <= '0;
                        r_we    <= 1'b0;
                        r_state <= S_ERR;
                    end else if (wbm_rty_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_sel <= '0;
                        r_gap <= 1'b1;
                    end else if (wbm_ack_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_sel <= '0;
                        if (r_state == S_RD) begin
                            r_wdat  <= wbm_dat_i;
                            r_adr   <= r_dst;
                            r_we    <= 1'b1;
                            r_gap   <= 1'b1;
                            r_state <= S_WR;
                        end else begin
                            r_src <= r_src + 32'd4;
                            r_dst <= r_dst + 32'd4;
                            r_cnt <= r_cnt - LEN_W'(1);
                            r_we  <= 1'b0;
                            if (r_cnt == LEN_W'(1)) begin
                                r_state <= S_DONE;
                            end else begin
                                r_adr   <= r_src + 32'd4;
                                r_gap   <= 1'b1;
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wbs_dat_o  = r_rdat;
    assign wbs_ack_o  = r_ack;
    assign wbs_err_o  = 1'b0;
    assign wbs_rty_o  = 1'b0;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_wdat;
    assign wbm_sel_o  = r_sel;
    assign wbm_we_o   = r_we;
    assign wbm_stb_o  = r_stb;
    assign wbm_cyc_o  = r_cyc;
    assign wbm_cab_o  = 1'b0;
    assign wb_int_o   = r_int;
    assign ctrl_state = r_state;

endmodule

// File: tb/tb_adma_core.sv
// Testbench for adma_core: directed jobs from the block description plus
// randomized copy jobs with injected err/rty, checked against a word-level
// model of what a copy job must leave in memory and in the status bits.
module tb_adma_core;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_stb_i, wbs_cyc_i, wbs_cab_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_cab_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic        wb_int_o;
    logic [7:0]  ctrl_state;
    logic        spi_clk_o, spi_do_o, spi_sel_o, spi_en, spi_di_i;

    adma_core #(.LEN_W(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
        .wbs_cab_i(wbs_cab_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_cab_o(wbm_cab_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .wb_int_o(wb_int_o), .ctrl_state(ctrl_state),
        .spi_clk_o(spi_clk_o), .spi_do_o(spi_do_o), .spi_sel_o(spi_sel_o),
        .spi_en(spi_en), .spi_di_i(spi_di_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model behind the master port: ack/err/rty one cycle after stb.
    bit [31:0]   mem [bit [31:0]];
    int          err_rd_idx = 99;
    int          rty_wr_idx = 99;
    int          rd_count = 0;
    int          wr_count = 0;
    int          rty_phase = 0;
    bit          rty_done = 1'b0;
    bit          pend_wait = 1'b0;
    logic [31:0] rty_adr, rty_dat;

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    initial begin
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = '0;
        forever begin
            @(posedge wb_clk_i); #1;
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
            if (rty_phase == 1) begin
                chk("rty_drop_stb", wbm_stb_o, 0);
                rty_phase = 2;
            end else if (rty_phase == 2) begin
                chk("rty_reissue_stb", wbm_stb_o, 1);
                chk("rty_reissue_adr", wbm_adr_o, rty_adr);
                chk("rty_reissue_dat", wbm_dat_o, rty_dat);
                chk("rty_reissue_sel", wbm_sel_o, 4'hF);
                rty_phase = 0;
            end
            if (wbm_cyc_o && wbm_stb_o) begin
                if (!pend_wait) pend_wait = 1'b1;
                else begin
                    pend_wait = 1'b0;
                    if (!wbm_we_o) begin
                        if (rd_count == err_rd_idx) wbm_err_i = 1'b1;
                        else begin
                            wbm_ack_i = 1'b1;
                            wbm_dat_i = mem_rd(wbm_adr_o);
                            rd_count++;
                        end
                    end else if (wr_count == rty_wr_idx && !rty_done) begin
                        wbm_rty_i = 1'b1;
                        rty_done  = 1'b1;
                        rty_adr   = wbm_adr_o;
                        rty_dat   = wbm_dat_o;
                        rty_phase = 1;
                    end else begin
                        wbm_ack_i = 1'b1;
                        mem[wbm_adr_o] = wbm_dat_o;
                        wr_count++;
                    end
                end
            end else pend_wait = 1'b0;
        end
    end

    // Records the sequence of distinct non-idle FSM codes and master cycles.
    logic [7:0] st_q[$];
    logic [7:0] last_st = 8'h00;
    int         cyc_cycles = 0;

    initial begin
        forever begin
            @(posedge wb_clk_i); #1;
            if (ctrl_state != last_st) begin
                if (ctrl_state != 8'h00) st_q.push_back(ctrl_state);
                last_st = ctrl_state;
            end
            if (wbm_cyc_o) cyc_cycles++;
        end
    end

    task automatic wbs_xfer(input logic we, input int idx, input logic [31:0] wd,
                            output logic [31:0] rd);
        logic [2:0] i3;
        i3 = idx[2:0];
        @(posedge wb_clk_i); #1;
        wbs_adr_i = {27'b0, i3, 2'b00};
        wbs_dat_i = wd;
        wbs_we_i  = we;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        @(posedge wb_clk_i); #1;
        chk($sformatf("wbs_ack_reg%0d", idx), wbs_ack_o, 1);
        rd = wbs_dat_o;
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input logic ie, input int err_at, input int rty_at, input bit probe);
        logic [31:0] rd;
        logic [31:0] sw[$];
        logic [7:0]  exp_q[$];
        logic [31:0] e;
        int          ncopy;
        bit          is_err;
        int          t;
        for (int i = 0; i < len; i++) begin
            sw.push_back($urandom);
            mem[src + 32'(4 * i)] = sw[i];
            mem[dst + 32'(4 * i)] = 32'hDEAD_0000 | 32'(i);
        end
        mem[dst + 32'(4 * len)] = 32'hBEEF_BEEF;
        // Reference: an error on read k leaves exactly k words copied.
        is_err = (err_at < len);
        ncopy  = is_err ? err_at : len;
        for (int i = 0; i < ncopy; i++) begin
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h02);
        end
        if (is_err) begin
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h04);
        end else exp_q.push_back(8'h03);

        err_rd_idx = err_at; rty_wr_idx = rty_at;
        rd_count = 0; wr_count = 0; rty_done = 1'b0;
        wbs_xfer(1'b1, 2, src, rd);
        wbs_xfer(1'b1, 3, dst, rd);
        wbs_xfer(1'b1, 4, 32'(len), rd);
        st_q.delete();
        cyc_cycles = 0;
        wbs_xfer(1'b1, 0, {30'b0, ie, 1'b1}, rd);
        if (len == 0) begin
            wbs_xfer(1'b0, 1, 0, rd);
            chk("len0_status", rd, 32'h2);
        end
        if (probe) begin
            wbs_xfer(1'b0, 1, 0, rd);
            chk("busy_status", rd, 32'h1);
            wbs_xfer(1'b1, 2, 32'hABCD_0000, rd);
            wbs_xfer(1'b0, 2, 0, rd);
            chk("src_locked", rd, src);
        end
        t = 0;
        while (ctrl_state != 8'h00 && t < 500) begin
            @(posedge wb_clk_i); #1;
            t++;
        end
        chk("job_timeout", 32'(t >= 500), 0);
        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("int_level", wb_int_o, ie);
        wbs_xfer(1'b0, 1, 0, rd);
        chk("status", rd, is_err ? 32'h4 : 32'h2);
        wbs_xfer(1'b0, 0, 0, rd);
        chk("ctrl_rd", rd, {30'b0, ie, 1'b0});
        chk("seq_len", st_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < st_q.size(); i++)
            chk($sformatf("seq%0d", i), st_q[i], exp_q[i]);
        if (len == 0) chk("len0_no_cyc", cyc_cycles, 0);
        for (int i = 0; i < len; i++) begin
            e = (i < ncopy) ? sw[i] : (32'hDEAD_0000 | 32'(i));
            chk($sformatf("dst_word%0d", i), mem_rd(dst + 32'(4 * i)), e);
        end
        chk("dst_guard", mem_rd(dst + 32'(4 * len)), 32'hBEEF_BEEF);
        wbs_xfer(1'b1, 1, 32'h6, rd);
        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("int_clr", wb_int_o, 0);
        wbs_xfer(1'b0, 1, 0, rd);
        chk("status_clr", rd, 32'h0);
        err_rd_idx = 99; rty_wr_idx = 99;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] s, d;
        int          ln, ea, ra;
        logic        ie;
        wb_rst_i = 1'b1;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = 4'hF;
        wbs_we_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_cab_i = 1'b0;
        spi_di_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
        chk("rst_state", ctrl_state, 0);
        chk("rst_int_ack", {wb_int_o, wbs_ack_o}, 0);
        chk("rst_err_rty_cab", {wbs_err_o, wbs_rty_o, wbm_cab_o}, 0);
        chk("rst_adr", wbm_adr_o, 0);
        wb_rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            wbs_xfer(1'b0, i, 0, rd);
            chk($sformatf("rst_reg%0d", i), rd, 0);
        end

        wbs_xfer(1'b1, 2, 32'h1000, rd);
        wbs_xfer(1'b1, 3, 32'h2000, rd);
        wbs_xfer(1'b1, 4, 32'h4, rd);
        wbs_xfer(1'b0, 2, 0, rd); chk("rb_src", rd, 32'h1000);
        wbs_xfer(1'b0, 3, 0, rd); chk("rb_dst", rd, 32'h2000);
        wbs_xfer(1'b0, 4, 0, rd); chk("rb_len", rd, 32'h4);
        wbs_xfer(1'b1, 4, 32'h0003_0005, rd);
        wbs_xfer(1'b0, 4, 0, rd); chk("rb_len_width", rd, 32'h5);

        run_job(32'h1000, 32'h2000, 4, 1'b1, 99, 99, 1'b1);
        run_job(32'h1000, 32'h2000, 0, 1'b1, 99, 99, 1'b0);
        run_job(32'h1100, 32'h2100, 4, 1'b1, 1, 99, 1'b0);
        run_job(32'h1200, 32'h2200, 4, 1'b1, 99, 0, 1'b0);
        run_job(32'hFFFF_FFF8, 32'h3000, 4, 1'b0, 99, 99, 1'b0);

        for (int n = 0; n < 10; n++) begin
            ln = $urandom_range(0, 6);
            s  = 32'h4000 + 32'($urandom_range(0, 15)) * 32'h100;
            d  = 32'h10000 + 32'($urandom_range(0, 15)) * 32'h100;
            ie = 1'($urandom_range(0, 1));
            ea = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 99;
            ra = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : 99;
            run_job(s, d, ln, ie, ea, ra, 1'b0);
        end

        // Reset in the middle of a job clears the bus at once, without a clock edge.
        wbs_xfer(1'b1, 2, 32'h5000, rd);
        wbs_xfer(1'b1, 3, 32'h6000, rd);
        wbs_xfer(1'b1, 4, 32'h8, rd);
        wbs_xfer(1'b1, 0, 32'h3, rd);
        repeat (4) @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("arst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
        chk("arst_state", ctrl_state, 0);
        chk("arst_sel_adr", {wbm_sel_o, wbm_adr_o[27:0]}, 0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        wbs_xfer(1'b0, 4, 0, rd); chk("arst_len", rd, 0);
        wbs_xfer(1'b0, 1, 0, rd); chk("arst_status", rd, 0);
        wbs_xfer(1'b0, 0, 0, rd); chk("arst_ctrl", rd, 0);

        wbs_xfer(1'b1, 5, 32'hF, rd);
        spi_di_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wbs_xfer(1'b0, 5, 0, rd);
`ifdef ADMA_SPI_EN
        chk("spi_out", {spi_en, spi_sel_o, spi_do_o, spi_clk_o}, 4'hF);
        chk("spi_rd", rd, 32'h10F);
`else
        chk("spi_out", {spi_en, spi_sel_o, spi_do_o, spi_clk_o}, 4'h0);
        chk("spi_rd", rd, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
